// File: rtl/cache_mem_adapter.sv
// cache_mem_adapter: memory-side stage below the cache controller FSM.
// Turns a line fill (mem_read) or line writeback (mem_write) into a burst of
// single-word transactions on the main-memory port, then pulses ca_resp.
// Optional build macro CACHE_MEM_TIMEOUT_EN adds a per-word ack watchdog that
// aborts the burst and reports ca_err; without it ca_err is tied low.
//
// Memory handshake: mm_req/mm_we/mm_addr/mm_wdata are held stable while
// mm_req=1 until a cycle with mm_ack=1; that cycle completes the word (and
// mm_rdata is sampled on reads). mm_ack while mm_req=0 is ignored.
module cache_mem_adapter #(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [ADDR_W-1:0]                line_addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] wb_data,
    output logic [WORD_W*WORDS_PER_LINE-1:0] fill_data,
    output logic                             ca_resp,
    output logic                             ca_err,
    output logic                             mm_req,
    output logic                             mm_we,
    output logic [ADDR_W-1:0]                mm_addr,
    output logic [WORD_W-1:0]                mm_wdata,
    input  logic [WORD_W-1:0]                mm_rdata,
    input  logic                             mm_ack
);

    localparam int BPW    = WORD_W / 8;
    localparam int CNT_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int OFF_W  = $clog2(WORDS_PER_LINE * BPW);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   base;
    logic [LINE_W-1:0]   wb_q;

    logic [ADDR_W-1:0]   line_base;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                last_word;

    // Offset bits of the line address select a byte inside the line and are
    // deliberately dropped; the burst always starts at the line base.
    logic unused_offset;
    assign unused_offset = ^line_addr[OFF_W-1:0];

    assign line_base = {line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign cnt_nxt   = cnt + 1'b1;
    assign addr_nxt  = base + ADDR_W'(int'(cnt_nxt) * BPW);
    assign last_word = (cnt == LAST);

`ifdef CACHE_MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    logic            ca_err_q;
    assign ca_err = ca_err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign ca_err = 1'b0;
`endif

    // Burst FSM with all memory-port and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            wb_q      <= '0;
            mm_req    <= 1'b0;
            mm_we     <= 1'b0;
            mm_addr   <= '0;
            mm_wdata  <= '0;
            fill_data <= '0;
            ca_resp   <= 1'b0;
`ifdef CACHE_MEM_TIMEOUT_EN
            wd        <= '0;
            ca_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef CACHE_MEM_TIMEOUT_EN
                    wd  <= '0;
`endif
                    // A simultaneous read is dropped: the writeback must go
                    // out first and the FSM re-issues the fill afterwards.
                    if (mem_write) begin
                        base     <= line_base;
                        wb_q     <= wb_data;
                        mm_req   <= 1'b1;
                        mm_we    <= 1'b1;
                        mm_addr  <= line_base;
                        mm_wdata <= wb_data[WORD_W-1:0];
                        state    <= WR_BURST;
                    end else if (mem_read) begin
                        base     <= line_base;
                        mm_req   <= 1'b1;
                        mm_we    <= 1'b0;
                        mm_addr  <= line_base;
                        mm_wdata <= '0;
                        state    <= RD_BURST;
                    end
                end
                WR_BURST, RD_BURST: begin
                    if (mm_ack) begin
                        if (state == RD_BURST) begin
                            fill_data[int'(cnt)*WORD_W +: WORD_W] <= mm_rdata;
                        end
`ifdef CACHE_MEM_TIMEOUT_EN
                        wd <= '0;
`endif
                        if (last_word) begin
                            mm_req  <= 1'b0;
                            mm_we   <= 1'b0;
                            ca_resp <= 1'b1;
                            state   <= RESP;
                        end else begin
                            cnt     <= cnt_nxt;
                            mm_addr <= addr_nxt;
                            if (state == WR_BURST) begin
                                mm_wdata <= wb_q[int'(cnt_nxt)*WORD_W +: WORD_W];
                            end
                        end
                    end
`ifdef CACHE_MEM_TIMEOUT_EN
                    // wd counts unacked cycles of the current word; the
                    // abort fires on the TIMEOUT_CYCLES-th such cycle.
                    else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        mm_req   <= 1'b0;
                        mm_we    <= 1'b0;
                        ca_resp  <= 1'b1;
                        ca_err_q <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                RESP: begin
                    ca_resp <= 1'b0;
`ifdef CACHE_MEM_TIMEOUT_EN
                    ca_err_q <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
